// File: rtl/hmem_loader.sv
// Fill stage for the polynomial memory: reduces a stream of coefficients from [0, 2Q) to [0, Q),
// writes them to consecutive addresses from BASE_ADDR, then zero-pads the operand up to PAD_LEN words.
module hmem_loader #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11,
  parameter int IN_WIDTH      = 14,
  parameter int Q             = 5167,
  parameter int N_COEFF       = 757,
  parameter int PAD_LEN       = 768,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [IN_WIDTH-1:0]      in_data,
  output logic                     in_ready,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] write_address,
  output logic [RAM_WIDTH-1:0]     input_data,
  output logic                     busy,
  output logic                     done,
  output logic                     range_err
);

  localparam int CW = RAM_ADDR_BITS + 1;
  localparam logic [CW-1:0] LAST_COEFF = CW'(N_COEFF - 1);
  localparam logic [CW-1:0] COEFF_END = CW'(N_COEFF);
  localparam logic [CW-1:0] PAD_END = CW'(PAD_LEN);
  localparam logic [IN_WIDTH:0] Q_EXT = (IN_WIDTH + 1)'(Q);
  localparam logic [RAM_ADDR_BITS-1:0] BASE = RAM_ADDR_BITS'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [IN_WIDTH:0] x_ext;
  logic [IN_WIDTH:0] x_sub;
  logic [IN_WIDTH:0] reduced_full;
  logic              over;
  logic              handshake;

  // A single conditional subtraction; a result still >= Q means the input was >= 2Q.
  always_comb begin
    x_ext        = {1'b0, in_data};
    x_sub        = x_ext - Q_EXT;
    reduced_full = (x_ext < Q_EXT) ? x_ext : x_sub;
    over         = (reduced_full >= Q_EXT);
    handshake    = in_valid & in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      in_ready      <= 1'b0;
      write_enable  <= 1'b0;
      write_address <= '0;
      input_data    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            count     <= '0;
            range_err <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (handshake) begin
            write_enable  <= 1'b1;
            write_address <= BASE + count[RAM_ADDR_BITS-1:0];
            input_data    <= reduced_full[RAM_WIDTH-1:0];
            count         <= count + CW'(1);
            if (over) begin
              range_err <= 1'b1;
            end
            if (count == LAST_COEFF) begin
              in_ready <= 1'b0;
              if (PAD_LEN > N_COEFF) begin
                state <= PAD;
              end
            end
          end else if (count == COEFF_END) begin
            // Unpadded build: one drain cycle lets the last write land before done.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        PAD: begin
          if (count == PAD_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            write_enable  <= 1'b1;
            write_address <= BASE + count[RAM_ADDR_BITS-1:0];
            input_data    <= '0;
            count         <= count + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hmem_loader.sv
// Randomised bench for hmem_loader: a padded build and an unpadded build at BASE_ADDR 1024 share the
// same stimulus; every write is scored against a reduction model fed by the observed handshakes.
module tb_hmem_loader;

  localparam int Q       = 5167;
  localparam int N_COEFF = 757;
  localparam int PAD0    = 768;
  localparam int BASE0   = 0;
  localparam int PAD1    = 757;
  localparam int BASE1   = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [13:0] in_data = '0;
  logic [1:0]  in_ready, write_enable, busy, done, range_err;
  logic [10:0] addr0, addr1;
  logic [12:0] data0, data1;

  hmem_loader #(.PAD_LEN(PAD0), .BASE_ADDR(BASE0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .write_enable(write_enable[0]), .write_address(addr0),
    .input_data(data0), .busy(busy[0]), .done(done[0]), .range_err(range_err[0])
  );

  hmem_loader #(.PAD_LEN(PAD1), .BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .write_enable(write_enable[1]), .write_address(addr1),
    .input_data(data1), .busy(busy[1]), .done(done[1]), .range_err(range_err[1])
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          quiet = 1'b0;
  logic [12:0] exp_data [2][N_COEFF];
  logic [12:0] tb_mem [2][2048];
  int          hs_cnt [2];
  int          wr_cnt [2];
  int          done_cnt [2];
  int          last_we_cyc [2];
  int          done_cyc [2];
  bit          exp_range [2];
  bit          prev_hs [2];
  bit          prev_wait [2];

  function automatic int pad_of(input int d);
    return (d == 0) ? PAD0 : PAD1;
  endfunction

  function automatic int base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  // Behavioural reduction: subtract Q once when the input is at least Q, keep the low 13 bits.
  function automatic logic [12:0] ref_reduce(input int x);
    if (x < Q) return 13'(x);
    return 13'(x - Q);
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      hs_cnt[d] = 0;
      wr_cnt[d] = 0;
      done_cnt[d] = 0;
      last_we_cyc[d] = -1;
      done_cyc[d] = -1;
      exp_range[d] = 1'b0;
      prev_hs[d] = 1'b0;
      prev_wait[d] = 1'b0;
      for (int a = 0; a < 2048; a++) tb_mem[d][a] = 13'h1fff;
    end
  endtask

  task automatic monitor_dut(input int d, input logic rdy, input logic we, input logic [10:0] addr,
                             input logic [12:0] data, input logic bsy, input logic dn);
    if (!rst_n) begin
      checkOutput("we_in_reset", we, 0);
      prev_hs[d] = 1'b0;
      prev_wait[d] = 1'b0;
    end else begin
      if (prev_hs[d]) checkOutput("we_after_handshake", we, 1);
      if (prev_wait[d]) checkOutput("we_during_gap", we, 0);
      if (quiet) begin
        checkOutput("idle_we", we, 0);
        checkOutput("idle_ready", rdy, 0);
      end
      if (we) begin
        checkOutput("wr_addr", addr, base_of(d) + wr_cnt[d]);
        if (wr_cnt[d] >= pad_of(d)) checkOutput("extra_write", wr_cnt[d], pad_of(d) - 1);
        if (wr_cnt[d] < N_COEFF) begin
          if (wr_cnt[d] < hs_cnt[d]) checkOutput("wr_data", data, exp_data[d][wr_cnt[d]]);
          else checkOutput("wr_before_handshake", wr_cnt[d], hs_cnt[d]);
        end else begin
          checkOutput("pad_data", data, 0);
        end
        tb_mem[d][addr] = data;
        wr_cnt[d]++;
        last_we_cyc[d] = cyc;
      end
      if (dn) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
        checkOutput("busy_at_done", bsy, 0);
        checkOutput("writes_before_done", wr_cnt[d], pad_of(d));
      end
      if (rdy) checkOutput("busy_in_load", bsy, 1);
      prev_hs[d] = in_valid && rdy;
      prev_wait[d] = rdy && !in_valid;
      if (prev_hs[d]) begin
        if (hs_cnt[d] < N_COEFF) begin
          exp_data[d][hs_cnt[d]] = ref_reduce(int'(in_data));
          if (int'(in_data) >= 2 * Q) exp_range[d] = 1'b1;
          hs_cnt[d]++;
        end else begin
          checkOutput("extra_handshake", hs_cnt[d], N_COEFF - 1);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    monitor_dut(0, in_ready[0], write_enable[0], addr0, data0, busy[0], done[0]);
    monitor_dut(1, in_ready[1], write_enable[1], addr1, data1, busy[1], done[1]);
  end

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput({tag, "_ready"}, in_ready[d], 0);
      checkOutput({tag, "_we"}, write_enable[d], 0);
      checkOutput({tag, "_busy"}, busy[d], 0);
      checkOutput({tag, "_done"}, done[d], 0);
      checkOutput({tag, "_range_err"}, range_err[d], 0);
    end
    checkOutput({tag, "_addr0"}, addr0, 0);
    checkOutput({tag, "_addr1"}, addr1, 0);
    checkOutput({tag, "_data0"}, data0, 0);
    checkOutput({tag, "_data1"}, data1, 0);
  endtask

  // data_mode: 0 ramp, 1 random in [0,2Q), 2 boundary values then mixed out-of-range.
  // valid_mode: 0 held high, 1 pattern 1,0,0 repeating, 2 random.
  task automatic applyStimulus(input int data_mode, input int valid_mode, input int abort_at,
                               input bit poke_start);
    int  vals [N_COEFF];
    int  bnd [5];
    int  cycles;
    int  idx;
    bit  poked;
    bnd = '{0, 5166, 5167, 10333, 10334};
    for (int i = 0; i < N_COEFF; i++) begin
      case (data_mode)
        0: vals[i] = i;
        1: vals[i] = int'($urandom_range(0, 2 * Q - 1));
        default: begin
          if (i < 5) vals[i] = bnd[i];
          else if ($urandom_range(0, 3) == 0) vals[i] = int'($urandom_range(2 * Q, 16383));
          else vals[i] = int'($urandom_range(0, 2 * Q - 1));
        end
      endcase
    end
    reset_model();
    quiet = 1'b1;
    in_valid = 1'b1;
    in_data = 14'(vals[0]);
    repeat (3) @(posedge clk);
    #1;
    quiet = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    poked = 1'b0;
    while (hs_cnt[0] < N_COEFF && cycles < 20000 && !(abort_at > 0 && hs_cnt[0] >= abort_at)) begin
      idx = hs_cnt[0];
      case (valid_mode)
        0: in_valid = 1'b1;
        1: in_valid = (cycles % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = 14'(vals[idx]);
      if (poke_start && !poked && idx >= 100) begin
        start = 1'b1;
        poked = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end
    in_valid = 1'b0;
    checkOutput("stream_timeout", int'(cycles < 20000), 1);
    if (abort_at == 0) begin
      cycles = 0;
      while ((done_cnt[0] == 0 || done_cnt[1] == 0) && cycles < 100) begin
        @(posedge clk);
        #1;
        cycles++;
      end
      checkOutput("done_timeout", int'(done_cnt[0] > 0 && done_cnt[1] > 0), 1);
      repeat (5) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput("write_count", wr_cnt[d], pad_of(d));
        checkOutput("done_pulses", done_cnt[d], 1);
        checkOutput("done_latency", done_cyc[d] - last_we_cyc[d], 1);
        checkOutput("range_err", range_err[d], int'(exp_range[d]));
        checkOutput("busy_after", busy[d], 0);
        for (int i = 0; i < pad_of(d); i++)
          checkOutput("mem", tb_mem[d][base_of(d) + i], (i < N_COEFF) ? int'(ref_reduce(vals[i])) : 0);
      end
      if (data_mode == 0) begin
        checkOutput("ramp_mem_300", tb_mem[0][300], 300);
        checkOutput("ramp_mem_756", tb_mem[0][756], 756);
        checkOutput("ramp_pad_767", tb_mem[0][767], 0);
        checkOutput("ramp_range_err", range_err[0], 0);
        checkOutput("variant_last", tb_mem[1][1780], 756);
        checkOutput("variant_no_pad", tb_mem[1][1781], 8191);
      end
      if (data_mode == 2) begin
        checkOutput("bnd_0", tb_mem[0][0], 0);
        checkOutput("bnd_q_minus_1", tb_mem[0][1], 5166);
        checkOutput("bnd_q", tb_mem[0][2], 0);
        checkOutput("bnd_2q_minus_1", tb_mem[0][3], 5166);
        checkOutput("bnd_2q", tb_mem[0][4], 5167);
        checkOutput("bnd_range_err", range_err[0], 1);
      end
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 0, 1'b0);
    applyStimulus(2, 0, 0, 1'b0);
    applyStimulus(1, 1, 0, 1'b1);
    applyStimulus(2, 2, 0, 1'b0);
    applyStimulus(2, 0, 300, 1'b0);
    checkOutput("pre_reset_busy", busy[0], 1);
    checkOutput("pre_reset_range_err", range_err[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midload_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hmem_loader.md
Name: hmem_loader

Overview:
- Upstream fill stage for the distributed polynomial memory (13-bit words, 2048 entries).
- Accepts a valid/ready stream of raw coefficients and reduces each one from [0, 2Q) to [0, Q).
- Writes the reduced coefficients to consecutive memory addresses, then zero-pads up to PAD_LEN entries so downstream arithmetic sees a fixed-length operand.
- Drives the memory's write_enable / write_address / input_data port directly.

Parameters:
- RAM_WIDTH, 13, data width of memory words.
- RAM_ADDR_BITS, 11, memory address width.
- IN_WIDTH, 14, width of raw input coefficients.
- Q, 5167, modulus; reduced outputs lie in [0, Q).
- N_COEFF, 757, number of coefficients accepted per load.
- PAD_LEN, 768, total words written per load; PAD_LEN >= N_COEFF, and BASE_ADDR+PAD_LEN <= 2**RAM_ADDR_BITS.
- BASE_ADDR, 0, first memory address written.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- in_valid  in  1  input coefficient valid.
- in_data  in  IN_WIDTH  raw coefficient, expected in [0, 2Q).
- in_ready  out  1  loader can accept a coefficient.
- write_enable  out  1  memory write strobe.
- write_address  out  RAM_ADDR_BITS  memory write address.
- input_data  out  RAM_WIDTH  memory write data.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final write.
- range_err  out  1  sticky flag: some accepted in_data was >= 2Q; cleared on start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter=0; in_ready, write_enable, busy, done, range_err = 0; write_address=0; input_data=0.
- States: IDLE, LOAD, PAD, DONE.
- IDLE:
  - start=1 -> LOAD, counter=0, range_err cleared.
  - in_valid is ignored because in_ready=0.
- LOAD:
  - in_ready=1.
  - A handshake occurs when in_valid=1 and in_ready=1.
  - Each handshake registers write_enable=1, write_address=BASE_ADDR+counter and input_data=reduced(in_data), visible the next cycle (latency 1), then counter+1.
  - On the handshake with counter=N_COEFF-1: in_ready drops the next cycle, then -> PAD if PAD_LEN>N_COEFF, else -> DONE.
  - Cycles without a handshake register write_enable=0.
- Reduction:
  - x<Q -> x.
  - Q<=x<2Q -> x-Q.
  - x>=2Q -> write (x-Q) truncated to RAM_WIDTH bits and set range_err.
  - The comparison uses IN_WIDTH+1 bits so nothing wraps.
- PAD:
  - in_ready=0.
  - Writes input_data=0 at addresses BASE_ADDR+N_COEFF through BASE_ADDR+PAD_LEN-1, one per cycle, write_enable=1 continuously.
  - After the write to BASE_ADDR+PAD_LEN-1 -> DONE.
- DONE:
  - write_enable=0, done=1 for exactly one cycle, then -> IDLE.
  - busy falls in the same cycle done rises.
- busy = 1 in LOAD and PAD.
- write_address and input_data hold their last values when write_enable=0.
- start outside IDLE (including the DONE cycle) is ignored.
- Reset asserted mid-load: everything returns to reset values immediately, no further writes; the memory contents are left partial.
- The address never wraps because of the BASE_ADDR+PAD_LEN constraint.

Test Plan:
- Basic load:
  - Stimulus: reset, start, stream 757 values in_data=i (i=0..756) with in_valid held high.
  - Required: mem[i]=i, mem[757..767]=0, done pulses once, exactly 768 writes, range_err=0.
- Reduction boundaries:
  - Stimulus: in_data = 0, 5166, 5167, 10333.
  - Required: written values 0, 5166, 0, 5166.
  - Stimulus: in_data = 10334.
  - Required: range_err=1, written value 5167.
- Back-pressure gaps:
  - Stimulus: in_valid toggles 1,0,0,1.
  - Required: write_enable follows one cycle later with no writes during the gaps; addresses stay contiguous; total latency = handshakes + 11 pad cycles + 1 done cycle.
- Ignored inputs:
  - Stimulus: start pulsed during LOAD.
  - Required: counter is not reset.
  - Stimulus: in_valid=1 while in IDLE.
  - Required: no write occurs.
- Mid-load reset:
  - Stimulus: rst_n pulled low after 300 handshakes.
  - Required: all outputs return to 0 asynchronously; a following start reloads from BASE_ADDR.
- Parameter variant:
  - Stimulus: PAD_LEN=N_COEFF=757, BASE_ADDR=1024.
  - Required: no PAD cycles; writes cover 1024..1780; done arrives one cycle after the last write.
